// File: rtl/fir_sample_source.sv
// fir_sample_source: buffered sample streamer feeding the FIR x input, followed by a zero flush
module fir_sample_source #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 2048,
    parameter int ADDR_W    = 11,
    parameter int FLUSH_LEN = 62
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   len,
    output logic [DATA_W-1:0] x,
    output logic              x_valid,
    input  logic              x_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sample_cnt
);
    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, FLUSH} state_t;

    state_t            r_state;
    logic [1:0]        r_rst_sync;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_mem_q;
    logic [DATA_W-1:0] r_x;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic [FW-1:0]     r_flush_cnt;
    logic              r_loop;
    logic              r_stop_pend;
    logic              r_x_valid;
    logic              r_done;

    logic              w_rst_n;
    logic              w_xfer;
    logic              w_adv;
    logic              w_last;
    logic              w_end;
    logic              w_go;
    logic [ADDR_W:0]   w_addr_inc;
    logic [ADDR_W:0]   w_cnt_next;
    logic [ADDR_W-1:0] w_rd_addr;

    // Reset asserts immediately, releases two clocks after RSTN rises
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_rst_sync <= 2'b00;
        else       r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // Next-read address keeps r_mem_q one sample ahead of x so streaming never bubbles
    always_comb begin
        w_xfer     = r_x_valid & x_ready;
        w_adv      = (r_state == STREAM) & (~r_x_valid | x_ready);
        w_addr_inc = {1'b0, r_rd_addr} + 1'b1;
        w_rd_addr  = (r_state != STREAM) ? '0 :
                     !w_adv              ? r_rd_addr :
                     (w_addr_inc == r_len) ? '0 : w_addr_inc[ADDR_W-1:0];
        w_last     = (r_cnt + 1'b1) == r_len;
        w_cnt_next = (w_last & r_loop) ? '0 : r_cnt + 1'b1;
        w_end      = stop | r_stop_pend | (w_last & ~r_loop);
        w_go       = start & ~stop & (len != '0);
    end

    // Sample buffer: writes land only while idle, reads are registered; contents survive reset
    always_ff @(posedge CLK) begin
        if (wr_en && r_state == IDLE) r_mem[wr_addr] <= wr_data;
        r_mem_q <= r_mem[w_rd_addr];
    end

    // Pass sequencer: prefetch entry 0, stream buffer samples, then drain with zeros
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_x_valid   <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_loop      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_flush_cnt <= '0;
            r_rd_addr   <= '0;
        end else begin
            r_done    <= 1'b0;
            r_rd_addr <= w_rd_addr;
            case (r_state)
                IDLE: if (w_go) begin
                    r_state     <= PREFETCH;
                    r_len       <= (len > DEPTH_L) ? DEPTH_L : len;
                    r_loop      <= loop_en;
                    r_cnt       <= '0;
                    r_stop_pend <= 1'b0;
                    r_flush_cnt <= '0;
                end
                PREFETCH: r_state <= STREAM;
                STREAM: if (!r_x_valid) begin
                    r_x_valid <= 1'b1;
                    r_state   <= stop ? FLUSH : STREAM;
                    r_x       <= stop ? '0 : r_mem_q;
                end else if (x_ready) begin
                    r_cnt   <= w_cnt_next;
                    r_state <= w_end ? FLUSH : STREAM;
                    r_x     <= w_end ? '0 : r_mem_q;
                end else if (stop) begin
                    r_stop_pend <= 1'b1;
                end
                FLUSH: if (w_xfer) begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    if (r_flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        r_state   <= IDLE;
                        r_x_valid <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign done       = r_done;
    assign sample_cnt = r_cnt;
    assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_fir_sample_source.sv
// tb_fir_sample_source: vector table, hand sequences and random back-pressure against a stream model
module tb_fir_sample_source;
    localparam int FLUSH_LEN = 62;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [9:0]  wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [11:0] len = '0;
    logic        x_ready = 1'b1;
    logic [9:0]  x;
    logic        x_valid;
    logic        busy;
    logic        done;
    logic [11:0] sample_cnt;

    fir_sample_source dut (
        .CLK(clk), .RSTN(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop_en(loop_en), .len(len), .x(x), .x_valid(x_valid),
        .x_ready(x_ready), .busy(busy), .done(done), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    logic [9:0] mdl [2048];
    logic [9:0] got [$];
    logic [9:0] exp_q [$];
    logic [9:0] px;
    logic       ph = 1'b0;

    typedef struct {
        int len;
        int mode;
        int exp_cnt;
        int exp_cyc;
    } vec_t;

    // Transfer recorder plus a check that x holds while the consumer stalls
    always @(negedge clk) begin
        if (!rst_n) begin
            ph = 1'b0;
        end else begin
            if (ph) begin
                total++;
                if (x !== px || x_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL hold: x=%0d valid=%0d, required x=%0d valid=1", x, x_valid, px);
                end
            end
            if (x_valid && x_ready) got.push_back(x);
            if (done) done_cnt++;
            ph = x_valid && !x_ready;
            px = x;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", n, a, e);
        end
    endtask

    task automatic wr(int a, logic [9:0] d);
        wr_en = 1'b1;
        wr_addr = 11'(a);
        wr_data = d;
        step();
        wr_en = 1'b0;
        mdl[a] = d;
    endtask

    task automatic cmp_stream(string n);
        int nerr = 0;
        chk({n, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            if (got[i] !== exp_q[i]) begin
                if (nerr == 0) $display("  %s first diff at %0d: got %0d, required %0d", n, i, got[i], exp_q[i]);
                nerr++;
            end
        chk({n, "_data"}, nerr, 0);
    endtask

    // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready, 3: ready high with mid-pass meddling
    task automatic wait_done(input int mode, input int budget, input bit first, inout int cyc);
        while (!done && cyc < budget) begin
            x_ready = (mode == 1) ? (cyc % 3 == 0) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 3 && cyc == 3) begin
                wr_en = 1'b1; wr_addr = 11'd1; wr_data = 10'h3ff;
                start = 1'b1; len = 12'd2; loop_en = 1'b1;
            end
            step();
            cyc++;
            wr_en = 1'b0; start = 1'b0; loop_en = 1'b0;
            if (first && cyc == 1) chk("valid_after_n1", x_valid, 0);
            if (first && cyc == 2) chk("first_x_after_n2", {x_valid, x}, {1'b1, mdl[0]});
        end
        x_ready = 1'b1;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
        end
    endtask

    task automatic run_pass(int l, int mode, int exp_cnt, int exp_cyc);
        int cyc = 0;
        got.delete();
        exp_q.delete();
        done_cnt = 0;
        for (int i = 0; i < exp_cnt; i++) exp_q.push_back(mdl[i]);
        repeat (FLUSH_LEN) exp_q.push_back('0);
        len = 12'(l);
        loop_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        wait_done(mode, 4 * (exp_cnt + FLUSH_LEN) + 20, 1'b1, cyc);
        if (exp_cyc >= 0) chk("pass_cycles", cyc, exp_cyc);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", x_valid, 0);
        chk("sample_cnt_final", sample_cnt, exp_cnt);
        step();
        chk("done_one_cycle", done, 0);
        chk("done_count", done_cnt, 1);
        cmp_stream("pass_stream");
    endtask

    initial begin
        vec_t vecs [8];
        int   cyc;
        vecs[0] = '{len: 4,    mode: 0, exp_cnt: 4,    exp_cyc: 68};
        vecs[1] = '{len: 4,    mode: 1, exp_cnt: 4,    exp_cyc: -1};
        vecs[2] = '{len: 1,    mode: 0, exp_cnt: 1,    exp_cyc: 65};
        vecs[3] = '{len: 16,   mode: 2, exp_cnt: 16,   exp_cyc: -1};
        vecs[4] = '{len: 4,    mode: 3, exp_cnt: 4,    exp_cyc: 68};
        vecs[5] = '{len: 4,    mode: 0, exp_cnt: 4,    exp_cyc: 68};
        vecs[6] = '{len: 4095, mode: 0, exp_cnt: 2048, exp_cyc: 2112};
        vecs[7] = '{len: 2048, mode: 2, exp_cnt: 2048, exp_cyc: -1};

        step();
        step();
        chk("rst_x", x, 0);
        chk("rst_valid", x_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        rst_n = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 2048; i++) wr(i, (i < 16) ? 10'(i) : 10'($urandom_range(0, 1023)));

        foreach (vecs[i]) run_pass(vecs[i].len, vecs[i].mode, vecs[i].exp_cnt, vecs[i].exp_cyc);

        got.delete();
        exp_q.delete();
        done_cnt = 0;
        len = 12'd3;
        loop_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        loop_en = 1'b0;
        len = 12'd5;
        step();
        chk("loop_valid_n1", x_valid, 0);
        for (int k = 0; k < 11; k++) begin
            step();
            chk("loop_seq", {x_valid, x}, {1'b1, mdl[k % 3]});
            exp_q.push_back(mdl[k % 3]);
        end
        chk("loop_no_done", done_cnt, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("loop_first_zero", {x_valid, x}, {1'b1, 10'd0});
        repeat (FLUSH_LEN) exp_q.push_back('0);
        cyc = 0;
        wait_done(0, 200, 1'b0, cyc);
        chk("loop_flush_cycles", cyc, FLUSH_LEN);
        chk("loop_sample_cnt", sample_cnt, 2);
        step();
        chk("loop_done_count", done_cnt, 1);
        cmp_stream("loop_stream");

        done_cnt = 0;
        len = 12'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("pre_reset_x", {x_valid, x}, {1'b1, mdl[2]});
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", x, 0);
        chk("arst_valid", x_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sample_cnt", sample_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("arst_no_done", done_cnt, 0);
        run_pass(4, 0, 4, 68);

        len = 12'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("len0_busy", busy, 0);
        len = 12'd4;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop_busy", busy, 0);

        for (int r = 0; r < 5; r++) begin
            int l;
            repeat (3) wr($urandom_range(0, 39), 10'($urandom_range(0, 1023)));
            l = $urandom_range(1, 40);
            run_pass(l, 2, l, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
